// File: rtl/ex_div.sv
// Multi-cycle radix-2 restoring divider for the EX stage (DIV/DIVU).
// Produces {remainder, quotient} one quotient bit per cycle; supports annul on flush.
module ex_div #(
  parameter int N_DATA = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_signed,
  input  logic [N_DATA-1:0]     i_opdata1,
  input  logic [N_DATA-1:0]     i_opdata2,
  input  logic                  i_annul,
  output logic [2*N_DATA-1:0]   o_result,
  output logic                  o_ready,
  output logic                  o_busy,
  output logic [1:0]            o_state
);

  // Handshake: EX holds i_start high until it sees o_ready, then drops it;
  // the result stays valid in END while i_start is held, and one FREE cycle
  // separates consecutive operations. i_annul cancels anything in flight.

  localparam int CW = $clog2(N_DATA) + 1;
  localparam logic [CW-1:0] LAST = CW'(N_DATA - 1);

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    BY_ZERO = 2'd1,
    ON      = 2'd2,
    END     = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [N_DATA-1:0]   rem_q, rem_d;
  logic [N_DATA-1:0]   dvd_q, dvd_d;
  logic [N_DATA-1:0]   dvs_q, dvs_d;
  logic                neg_q_q, neg_q_d;
  logic                neg_r_q, neg_r_d;
  logic [2*N_DATA-1:0] result_q, result_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;

  logic [N_DATA:0]     partial;
  logic [N_DATA:0]     diff;
  logic                qbit;
  logic [N_DATA-1:0]   rem_step;
  logic [N_DATA-1:0]   dvd_step;
  logic [N_DATA-1:0]   quo_fin;
  logic [N_DATA-1:0]   rem_fin;
  logic                op1_neg;
  logic                op2_neg;

  // One restoring step: the remainder register shifts in the next dividend bit,
  // and the dividend register fills up with quotient bits from the right.
  always_comb begin
    partial  = {rem_q, dvd_q[N_DATA-1]};
    diff     = partial - {1'b0, dvs_q};
    qbit     = ~diff[N_DATA];
    rem_step = qbit ? diff[N_DATA-1:0] : partial[N_DATA-1:0];
    dvd_step = {dvd_q[N_DATA-2:0], qbit};
    quo_fin  = neg_q_q ? (~dvd_step + 1'b1) : dvd_step;
    rem_fin  = neg_r_q ? (~rem_step + 1'b1) : rem_step;
    op1_neg  = i_signed & i_opdata1[N_DATA-1];
    op2_neg  = i_signed & i_opdata2[N_DATA-1];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    result_d = result_q;
    ready_d  = ready_q;
    case (state_q)
      FREE: begin
        result_d = '0;
        ready_d  = 1'b0;
        if (i_start && !i_annul) begin
          if (i_opdata2 == '0) begin
            state_d = BY_ZERO;
          end else begin
            state_d = ON;
            dvd_d   = op1_neg ? (~i_opdata1 + 1'b1) : i_opdata1;
            dvs_d   = op2_neg ? (~i_opdata2 + 1'b1) : i_opdata2;
            rem_d   = '0;
            cnt_d   = '0;
            neg_r_d = op1_neg;
            neg_q_d = op1_neg ^ op2_neg;
          end
        end
      end
      BY_ZERO: begin
        result_d = '0;
        if (i_annul) begin
          state_d = FREE;
          ready_d = 1'b0;
        end else begin
          state_d = END;
          ready_d = 1'b1;
        end
      end
      ON: begin
        if (i_annul) begin
          state_d  = FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end else begin
          rem_d = rem_step;
          dvd_d = dvd_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d  = END;
            ready_d  = 1'b1;
            result_d = {rem_fin, quo_fin};
          end
        end
      end
      END: begin
        if (!i_start || i_annul) begin
          state_d  = FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end
      end
      default: begin
        state_d  = FREE;
        ready_d  = 1'b0;
        result_d = '0;
      end
    endcase
    busy_d = (state_d == BY_ZERO) || (state_d == ON);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= FREE;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign o_result = result_q;
  assign o_ready  = ready_q;
  assign o_busy   = busy_q;
  assign o_state  = state_q;

endmodule

// File: tb/tb_ex_div.sv
// Bench for ex_div: directed corner cases plus random DIV/DIVU against an
// arithmetic reference, with a queue-based scoreboard checking result and latency.
module tb_ex_div;

  localparam int N = 32;

  logic           i_clk;
  logic           i_rst;
  logic           i_start;
  logic           i_signed;
  logic [N-1:0]   i_opdata1;
  logic [N-1:0]   i_opdata2;
  logic           i_annul;
  logic [2*N-1:0] o_result;
  logic           o_ready;
  logic           o_busy;
  logic [1:0]     o_state;

  ex_div #(.N_DATA(N)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (i_start),
    .i_signed  (i_signed),
    .i_opdata1 (i_opdata1),
    .i_opdata2 (i_opdata2),
    .i_annul   (i_annul),
    .o_result  (o_result),
    .o_ready   (o_ready),
    .o_busy    (o_busy),
    .o_state   (o_state)
  );

  // Clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc++;

  int checks   = 0;
  int failures = 0;

  logic [2*N-1:0] exp_q[$];
  int             lat_q[$];
  int             samp_q[$];

  task automatic chk(input string name, input logic [2*N-1:0] act, input logic [2*N-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: plain integer division; SV truncates toward zero and the
  // remainder takes the dividend's sign, matching DIV semantics.
  function automatic logic [2*N-1:0] ref_div(input logic sgn, input logic [N-1:0] a,
                                             input logic [N-1:0] b);
    longint sa, sb, q, r;
    logic [N-1:0] uq, ur;
    if (b == '0) return '0;
    if (!sgn) begin
      uq = a / b;
      ur = a % b;
      return {ur, uq};
    end
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {r[N-1:0], q[N-1:0]};
  endfunction

  // Monitor / scoreboard
  logic           prev_ready = 1'b0;
  logic [2*N-1:0] cur_exp    = '0;

  always @(negedge i_clk) begin
    if (o_ready && !prev_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ready", {63'd0, o_ready}, 64'd0);
      end else begin
        cur_exp = exp_q.pop_front();
        chk("result", o_result, cur_exp);
        chk("latency", 64'(cyc - samp_q.pop_front()), 64'(lat_q.pop_front()));
      end
    end else if (o_ready && prev_ready) begin
      chk("hold_result", o_result, cur_exp);
    end
    prev_ready = o_ready;
  end

  // Driver
  task automatic run_op(input logic sgn, input logic [N-1:0] a, input logic [N-1:0] b,
                        input int hold);
    int n;
    @(negedge i_clk);
    i_signed  = sgn;
    i_opdata1 = a;
    i_opdata2 = b;
    i_start   = 1'b1;
    exp_q.push_back(ref_div(sgn, a, b));
    lat_q.push_back((b == '0) ? 1 : N);
    samp_q.push_back(cyc + 1);
    @(negedge i_clk);
    chk("busy_after_start", {63'd0, o_busy}, 64'd1);
    i_opdata1 = N'($urandom);
    i_opdata2 = N'($urandom);
    i_signed  = 1'($urandom);
    n = 0;
    while (!o_ready && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_ready) chk("ready_timeout", 64'd0, 64'd1);
    chk("busy_in_end", {63'd0, o_busy}, 64'd0);
    repeat (hold) @(negedge i_clk);
    i_start = 1'b0;
    @(negedge i_clk);
    chk("ready_after_drop", {63'd0, o_ready}, 64'd0);
    chk("result_after_drop", o_result, 64'd0);
  endtask

  initial begin
    logic [N-1:0] a, b;
    i_rst = 1'b1; i_start = 1'b0; i_signed = 1'b0; i_annul = 1'b0;
    i_opdata1 = '0; i_opdata2 = '0;
    #12;
    chk("reset_result", o_result, 64'd0);
    chk("reset_ready_busy", {62'd0, o_ready, o_busy}, 64'd0);
    @(negedge i_clk);
    i_rst = 1'b0;

    // Directed corners
    run_op(1'b0, 32'd100, 32'd7, 5);
    run_op(1'b1, -32'sd7, 32'd2, 0);
    run_op(1'b1, 32'd7, -32'sd2, 1);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 0);
    run_op(1'b0, 32'd1234, 32'd0, 2);
    run_op(1'b1, 32'hFFFF_FFF0, 32'd0, 0);

    // Start together with annul in FREE is ignored
    @(negedge i_clk);
    i_start = 1'b1; i_annul = 1'b1; i_opdata1 = 32'd50; i_opdata2 = 32'd5;
    @(negedge i_clk);
    chk("annul_in_free_busy", {63'd0, o_busy}, 64'd0);
    i_start = 1'b0; i_annul = 1'b0;

    // Annul partway through the iterations
    @(negedge i_clk);
    i_signed = 1'b0; i_opdata1 = 32'd1000; i_opdata2 = 32'd3; i_start = 1'b1;
    repeat (10) @(negedge i_clk);
    i_annul = 1'b1; i_start = 1'b0;
    @(negedge i_clk);
    chk("annul_busy", {63'd0, o_busy}, 64'd0);
    chk("annul_ready_result", {o_result[62:0], o_ready}, 64'd0);
    i_annul = 1'b0;
    repeat (40) @(negedge i_clk);
    run_op(1'b0, 32'd9, 32'd3, 0);

    // Asynchronous reset in the middle of an operation
    @(negedge i_clk);
    i_signed = 1'b0; i_opdata1 = 32'd100; i_opdata2 = 32'd7; i_start = 1'b1;
    repeat (5) @(negedge i_clk);
    #2 i_rst = 1'b1;
    #1;
    chk("midrst_busy", {63'd0, o_busy}, 64'd0);
    chk("midrst_ready_result", {o_result[62:0], o_ready}, 64'd0);
    i_start = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
    repeat (40) @(negedge i_clk);

    // Random mix
    for (int i = 0; i < 60; i++) begin
      a = N'($urandom);
      case ($urandom_range(0, 7))
        0:       b = '0;
        1, 2:    b = N'($urandom_range(1, 15));
        3:       b = -N'($urandom_range(1, 15));
        default: b = N'($urandom);
      endcase
      run_op(1'($urandom), a, b, $urandom_range(0, 3));
    end

    repeat (3) @(negedge i_clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
